// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared LSU size encodings, FSM state enum and bytes-per-size helper
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } lsu_state_e;

    // Access width in bytes; the reserved encoding returns 0 and is faulted separately.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            SIZE_WORD: size_bytes = 3'd4;
            default:   size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - LSU request/response/memory bundle with master and slave modports
interface load_store_unit_if;

    // execute-stage request
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [4:0]  req_rd;

    // writeback response
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_fault;

    // synchronous-read data memory
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_is_signed;
    logic [31:0] mem_read_data;

    // LSU side
    modport slave (
        input  req_valid, req_base, req_offset, req_wdata, req_is_store,
               req_size, req_signed, req_rd, resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_data, resp_rd, resp_fault,
               mem_addr, mem_write_data, mem_read, mem_write, mem_size, mem_is_signed
    );

    // pipeline and memory side
    modport master (
        output req_valid, req_base, req_offset, req_wdata, req_is_store,
               req_size, req_signed, req_rd, resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_fault,
               mem_addr, mem_write_data, mem_read, mem_write, mem_size, mem_is_signed
    );

endinterface

// File: rtl/lsu_addr_check.sv
// rtl/lsu_addr_check.sv - combinational size/range/alignment fault check (alignment trap under LSU_MISALIGN_TRAP_EN)
module lsu_addr_check #(
    parameter int unsigned MEMORY_SIZE_BYTES = 1024
) (
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    output logic        fault_o
);
    import lsu_pkg::*;

    logic [32:0] end_addr;
    logic        size_bad;
    logic        range_bad;
    logic        misalign_bad;

    // One extra bit so an access touching the top of the 32-bit space cannot wrap past the range check.
    assign end_addr  = {1'b0, addr_i} + {30'b0, size_bytes(size_i)};
    assign size_bad  = (size_i == 2'b11);
    assign range_bad = (end_addr > 33'(MEMORY_SIZE_BYTES));

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_bad = ((size_i == SIZE_HALF) && addr_i[0]) ||
                          ((size_i == SIZE_WORD) && (addr_i[1:0] != 2'b00));
`else
    // Memory is byte-granular, so unaligned accesses are legal in this build.
    assign misalign_bad = 1'b0;
`endif

    assign fault_o = size_bad || range_bad || misalign_bad;

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit: request capture, IDLE/ISSUE/CAPTURE/RESP FSM, one-cycle memory strobes, held response (LSU_MISALIGN_TRAP_EN selects alignment trapping)
module load_store_unit #(
    parameter int unsigned MEMORY_SIZE_BYTES = 1024
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave lsu_bus
);
    import lsu_pkg::*;

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        store_q, store_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_fault_q, resp_fault_d;
    logic [4:0]  resp_rd_q, resp_rd_d;

    logic [31:0] eff_addr;
    logic        chk_fault;
    logic        in_issue;

    // Effective address wraps modulo 2^32; the check runs on the incoming request so a fault can skip ISSUE.
    assign eff_addr = lsu_bus.req_base + lsu_bus.req_offset;

    lsu_addr_check #(
        .MEMORY_SIZE_BYTES(MEMORY_SIZE_BYTES)
    ) u_addr_check (
        .addr_i (eff_addr),
        .size_i (lsu_bus.req_size),
        .fault_o(chk_fault)
    );

    // State and request/response registers; reset drops any in-flight request silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            store_q      <= 1'b0;
            rd_q         <= '0;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b0;
            resp_rd_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            store_q      <= store_d;
            rd_q         <= rd_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
            resp_rd_q    <= resp_rd_d;
        end
    end

    // Next-state and register updates for the four-state access sequence.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        signed_d     = signed_q;
        store_d      = store_q;
        rd_d         = rd_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;
        resp_rd_d    = resp_rd_q;

        case (state_q)
            IDLE: begin
                if (lsu_bus.req_valid) begin
                    addr_d   = eff_addr;
                    wdata_d  = lsu_bus.req_wdata;
                    size_d   = lsu_bus.req_size;
                    signed_d = lsu_bus.req_signed;
                    store_d  = lsu_bus.req_is_store;
                    rd_d     = lsu_bus.req_rd;
                    if (chk_fault) begin
                        // Faulting access reports its address and never touches memory.
                        resp_data_d  = eff_addr;
                        resp_fault_d = 1'b1;
                        resp_rd_d    = lsu_bus.req_rd;
                        state_d      = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (store_q) begin
                    resp_data_d  = '0;
                    resp_fault_d = 1'b0;
                    resp_rd_d    = rd_q;
                    state_d      = RESP;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // Memory registered the read at the end of ISSUE; its data is valid now.
                resp_data_d  = lsu_bus.mem_read_data;
                resp_fault_d = 1'b0;
                resp_rd_d    = rd_q;
                state_d      = RESP;
            end
            RESP: begin
                if (lsu_bus.resp_ready) begin
                    resp_data_d  = '0;
                    resp_fault_d = 1'b0;
                    resp_rd_d    = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_issue = (state_q == ISSUE);

    // Handshake outputs come from state only, so req_ready has no path from req_valid.
    assign lsu_bus.req_ready  = (state_q == IDLE);
    assign lsu_bus.resp_valid = (state_q == RESP);
    assign lsu_bus.resp_data  = resp_data_q;
    assign lsu_bus.resp_fault = resp_fault_q;
    assign lsu_bus.resp_rd    = resp_rd_q;

    // Memory bus is quiet (all zero) except during the single ISSUE cycle.
    assign lsu_bus.mem_read       = in_issue && !store_q;
    assign lsu_bus.mem_write      = in_issue && store_q;
    assign lsu_bus.mem_addr       = in_issue ? addr_q   : '0;
    assign lsu_bus.mem_write_data = in_issue ? wdata_q  : '0;
    assign lsu_bus.mem_size       = in_issue ? size_q   : '0;
    assign lsu_bus.mem_is_signed  = in_issue ? signed_q : 1'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a byte-array reference model
module tb_load_store_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [7:0] ref_mem [0:1023];
    logic [7:0] dev_mem [0:1023];

    load_store_unit_if bus ();

    load_store_unit #(
        .MEMORY_SIZE_BYTES(1024)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .lsu_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dev_read(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [7:0] b0, b1, b2, b3;
        b0 = dev_mem[a[9:0]];
        b1 = dev_mem[a[9:0] + 10'd1];
        b2 = dev_mem[a[9:0] + 10'd2];
        b3 = dev_mem[a[9:0] + 10'd3];
        case (sz)
            2'd0:    dev_read = {{24{sg & b0[7]}}, b0};
            2'd1:    dev_read = {{16{sg & b1[7]}}, b1, b0};
            default: dev_read = {b3, b2, b1, b0};
        endcase
    endfunction

    // Synchronous-read data memory attached to the LSU memory port.
    always @(posedge clk) begin
        if (bus.mem_write) begin
            dev_mem[bus.mem_addr[9:0]] <= bus.mem_write_data[7:0];
            if (bus.mem_size != 2'd0) dev_mem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_write_data[15:8];
            if (bus.mem_size == 2'd2) begin
                dev_mem[bus.mem_addr[9:0] + 10'd2] <= bus.mem_write_data[23:16];
                dev_mem[bus.mem_addr[9:0] + 10'd3] <= bus.mem_write_data[31:24];
            end
        end
        if (bus.mem_read) bus.mem_read_data <= dev_read(bus.mem_addr, bus.mem_size, bus.mem_is_signed);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, want test done first");
        $fatal(1);
    end

    task automatic run_req(input string name, input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] wdata, input logic st, input logic [1:0] sz,
                           input logic sg, input logic [4:0] rd, input int stall,
                           output logic [31:0] got_data, output logic got_fault);
        logic [31:0] ea, exp_data, s_addr, s_wdata, h_data;
        logic        exp_fault, s_wr, side_bad, stall_bad, h_fault;
        logic [4:0]  h_rd;
        longint      end_a;
        int          nb, exp_lat, lat, strobes, waitc;

        ea = base + off;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        end_a = longint'({32'b0, ea}) + nb;
        exp_fault = (sz == 2'd3) || (end_a > 1024);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((sz == 2'd1 && ea[0]) || (sz == 2'd2 && ea[1:0] != 2'b00)) exp_fault = 1'b1;
`endif
        exp_data = '0;
        if (exp_fault) begin
            exp_data = ea;
            exp_lat  = 1;
        end else if (st) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(ea) + i] = wdata[8*i +: 8];
            exp_lat = 2;
        end else begin
            for (int i = 0; i < nb; i++) exp_data[8*i +: 8] = ref_mem[int'(ea) + i];
            if (sg && nb == 1 && exp_data[7])  exp_data[31:8]  = '1;
            if (sg && nb == 2 && exp_data[15]) exp_data[31:16] = '1;
            exp_lat = 3;
        end

        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_base     = base;
        bus.req_offset   = off;
        bus.req_wdata    = wdata;
        bus.req_is_store = st;
        bus.req_size     = sz;
        bus.req_signed   = sg;
        bus.req_rd       = rd;
        waitc = 0;
        while (!bus.req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: req_ready=%b want 1", name, bus.req_ready);
            bus.req_valid = 1'b0;
            got_data = 'x;
            got_fault = 1'bx;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        lat = 0; strobes = 0; side_bad = 1'b0;
        s_addr = '0; s_wdata = '0; s_wr = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.req_ready !== 1'b0) side_bad = 1'b1;
            if (bus.mem_read || bus.mem_write) begin
                strobes++;
                s_addr = bus.mem_addr; s_wdata = bus.mem_write_data; s_wr = bus.mem_write;
                if (bus.mem_size !== sz || bus.mem_is_signed !== sg) side_bad = 1'b1;
            end else if (bus.mem_addr !== '0 || bus.mem_write_data !== '0 ||
                         bus.mem_size !== '0 || bus.mem_is_signed !== 1'b0) begin
                side_bad = 1'b1;
            end
            if (bus.resp_valid === 1'b1) break;
        end
        got_data = bus.resp_data;
        got_fault = bus.resp_fault;

        total++;
        if (lat !== exp_lat || bus.resp_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s latency: got %0d (valid=%b) want %0d", name, lat, bus.resp_valid, exp_lat);
        end
        total++;
        if (strobes !== (exp_fault ? 0 : 1)) begin
            bad++;
            $display("FAIL %s strobes: got %0d want %0d", name, strobes, exp_fault ? 0 : 1);
        end
        if (!exp_fault) begin
            total++;
            if (s_addr !== ea || s_wr !== st || (st && s_wdata !== wdata)) begin
                bad++;
                $display("FAIL %s strobe: addr=%h wr=%b wdata=%h want addr=%h wr=%b wdata=%h",
                         name, s_addr, s_wr, s_wdata, ea, st, wdata);
            end
        end
        total++;
        if (side_bad !== 1'b0) begin
            bad++;
            $display("FAIL %s bus_quiet: got violation=%b want 0", name, side_bad);
        end
        total++;
        if (bus.resp_data !== exp_data || bus.resp_fault !== exp_fault || bus.resp_rd !== rd) begin
            bad++;
            $display("FAIL %s resp: data=%h fault=%b rd=%0d want data=%h fault=%b rd=%0d",
                     name, bus.resp_data, bus.resp_fault, bus.resp_rd, exp_data, exp_fault, rd);
        end

        h_data = bus.resp_data; h_fault = bus.resp_fault; h_rd = bus.resp_rd;
        stall_bad = 1'b0;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_data !== h_data ||
                bus.resp_fault !== h_fault || bus.resp_rd !== h_rd) stall_bad = 1'b1;
        end
        if (stall > 0) begin
            total++;
            if (stall_bad !== 1'b0) begin
                bad++;
                $display("FAIL %s stall_hold: got violation=%b want 0", name, stall_bad);
            end
        end

        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s release: resp_valid=%b req_ready=%b want 0 1", name, bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_fault, bus.mem_read, bus.mem_write,
             bus.mem_addr, bus.mem_write_data, bus.mem_size, bus.mem_is_signed} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: resp_valid=%b data=%h mem_rd=%b mem_wr=%b addr=%h want all 0",
                     bus.resp_valid, bus.resp_data, bus.mem_read, bus.mem_write, bus.mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: req_ready=%b want 1", bus.req_ready);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] d;
        logic        f;
        run_req("sw_0x104", 32'h100, 32'h4, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0, 5'd3, 0, d, f);
        run_req("lw_0x104", 32'h104, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 5'd7, 0, d, f);
        total++;
        if (d !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL lw_literal: got %h want deadbeef", d);
        end
    endtask

    task automatic test_signed_byte();
        logic [31:0] d;
        logic        f;
        run_req("sb_0x80", 32'h200, 32'h1, 32'h1234_5680, 1'b1, 2'd0, 1'b0, 5'd1, 0, d, f);
        run_req("lb_0x80", 32'h200, 32'h1, 32'h0, 1'b0, 2'd0, 1'b1, 5'd2, 0, d, f);
        total++;
        if (d !== 32'hFFFFFF80) begin
            bad++;
            $display("FAIL lb_literal: got %h want ffffff80", d);
        end
        run_req("lbu_0x80", 32'h201, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd4, 0, d, f);
        total++;
        if (d !== 32'h00000080) begin
            bad++;
            $display("FAIL lbu_literal: got %h want 00000080", d);
        end
    endtask

    task automatic test_fault();
        logic [31:0] d;
        logic        f;
        run_req("lw_0x3fe", 32'h3F0, 32'hE, 32'h0, 1'b0, 2'd2, 1'b0, 5'd5, 0, d, f);
        total++;
        if (f !== 1'b1 || d !== 32'h3FE) begin
            bad++;
            $display("FAIL lw_range_literal: fault=%b data=%h want 1 3fe", f, d);
        end
        run_req("size_11", 32'h100, 32'h0, 32'h0, 1'b0, 2'd3, 1'b0, 5'd6, 0, d, f);
        run_req("sw_0x3fc", 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b1, 2'd2, 1'b0, 5'd8, 0, d, f);
        run_req("lb_0x3ff", 32'h3FF, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd9, 0, d, f);
        run_req("sh_0x101", 32'h101, 32'h0, 32'h0000A5C3, 1'b1, 2'd1, 1'b0, 5'd10, 0, d, f);
        run_req("lh_0x101", 32'h101, 32'h0, 32'h0, 1'b0, 2'd1, 1'b1, 5'd11, 0, d, f);
        total++;
`ifdef LSU_MISALIGN_TRAP_EN
        if (f !== 1'b1 || d !== 32'h101) begin
            bad++;
            $display("FAIL lh_misalign: fault=%b data=%h want 1 101", f, d);
        end
`else
        if (f !== 1'b0) begin
            bad++;
            $display("FAIL lh_misalign: fault=%b want 0", f);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic        f;
        run_req("sw_0x4", 32'h0, 32'h4, 32'h0BADF00D, 1'b1, 2'd2, 1'b0, 5'd12, 0, d, f);
        run_req("lw_wrap", 32'hFFFFFFFC, 32'h8, 32'h0, 1'b0, 2'd2, 1'b0, 5'd13, 0, d, f);
        total++;
        if (f !== 1'b0 || d !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL wrap_literal: fault=%b data=%h want 0 0badf00d", f, d);
        end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        logic        f;
        run_req("stall_lw", 32'h100, 32'h4, 32'h0, 1'b0, 2'd2, 1'b0, 5'd14, 5, d, f);
        run_req("stall_fault", 32'h400, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd15, 5, d, f);
    endtask

    task automatic test_reset_issue();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_base = 32'h300; bus.req_offset = 32'h0;
        bus.req_wdata = 32'h11223344; bus.req_is_store = 1'b1; bus.req_size = 2'd2;
        bus.req_signed = 1'b0; bus.req_rd = 5'd16;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h300) begin
            bad++;
            $display("FAIL rst_issue_pre: mem_write=%b addr=%h want 1 300", bus.mem_write, bus.mem_addr);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.mem_write !== 1'b0 || bus.mem_addr !== '0 || bus.mem_write_data !== '0 ||
            bus.mem_size !== '0 || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_issue: mem_write=%b addr=%h wdata=%h ready=%b want 0 0 0 1",
                     bus.mem_write, bus.mem_addr, bus.mem_write_data, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_capture();
        logic leak;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_base = 32'h104; bus.req_offset = 32'h0;
        bus.req_wdata = 32'h0; bus.req_is_store = 1'b0; bus.req_size = 2'd2;
        bus.req_signed = 1'b0; bus.req_rd = 5'd17;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_fault, bus.mem_read, bus.mem_write,
             bus.mem_addr, bus.mem_write_data, bus.mem_size, bus.mem_is_signed} !== '0 ||
            bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_capture: resp_valid=%b data=%h ready=%b want 0 0 1",
                     bus.resp_valid, bus.resp_data, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        leak = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) leak = 1'b1;
        end
        total++;
        if (leak !== 1'b0) begin
            bad++;
            $display("FAIL rst_capture_after: got stray response/busy=%b want 0", leak);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, base, target;
        logic        f;
        for (int n = 0; n < 40; n++) begin
            target = 32'($urandom_range(0, 1040));
            base   = $urandom;
            run_req("rand", base, target - base, $urandom, 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    $urandom_range(0, 2), d, f);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 8'h00;
            dev_mem[i] = 8'h00;
        end
        bus.req_valid = 1'b0; bus.req_base = '0; bus.req_offset = '0; bus.req_wdata = '0;
        bus.req_is_store = 1'b0; bus.req_size = '0; bus.req_signed = 1'b0; bus.req_rd = '0;
        bus.resp_ready = 1'b0;
        bus.mem_read_data = '0;
        rst = 1'b1;

        test_reset();
        test_store_load();
        test_signed_byte();
        test_fault();
        test_wrap();
        test_stall();
        test_reset_issue();
        test_reset_capture();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
